// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream frame checker.
// Holds the FSM state enum, err_flags bit indices and LFSR constants.
package axis_chk_pkg;

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } chk_state_e;

   localparam int ERR_DATA = 0;
   localparam int ERR_LAST = 1;
   localparam int ERR_KEEP = 2;
   localparam int ERR_USER = 3;

   // Fibonacci LFSR, taps 16,14,13,11 in right-shift form:
   // feedback = l[0]^l[2]^l[3]^l[5], shifted in at bit 15.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/axis_chk_lfsr.sv
// Backpressure generator: 16-bit Fibonacci LFSR advancing when en is high.
// Ports: aclk, aresetn (sync, active-low), en, ready_nx (ready for next cycle).
module axis_chk_lfsr
   import axis_chk_pkg::*;
(
   input  logic aclk,
   input  logic aresetn,
   input  logic en,
   output logic ready_nx
);

   logic [15:0] lfsr;
   logic [15:0] lfsr_nx;

   always_comb begin
      lfsr_nx = lfsr;
      if (en)
         lfsr_nx = {^(lfsr & LFSR_TAPS), lfsr[15:1]};
   end

   // Ready seen in a cycle is a function of the LFSR value held in
   // that cycle, so the registered tready looks one step ahead.
   assign ready_nx = (lfsr_nx[1:0] != 2'b00);

   always_ff @(posedge aclk) begin
      if (!aresetn)
         lfsr <= LFSR_SEED;
      else
         lfsr <= lfsr_nx;
   end

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream sink that checks an incrementing-data framed test stream.
// Ports: aclk, aresetn (sync, active-low), s_axis_* sink, frame_cnt,
// err_cnt, err_flags, frame_done, halted.
// Option: AXIS_CHK_BACKPRESSURE_EN adds LFSR-driven tready in RUN.
module axis_frame_checker
   import axis_chk_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int KEEP_W      = DATA_W / 8,
   parameter int USER_W      = 1,
   parameter int FRAME_BEATS = 8,
   parameter int START_DELAY = 2,
   parameter int HALT_ON_ERR = 0
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic [KEEP_W-1:0] s_axis_tkeep,
   input  logic              s_axis_tlast,
   input  logic [USER_W-1:0] s_axis_tuser,
   output logic [31:0]       frame_cnt,
   output logic [15:0]       err_cnt,
   output logic [3:0]        err_flags,
   output logic              frame_done,
   output logic              halted
);

   localparam int BIDX_W = $clog2(FRAME_BEATS);

   chk_state_e        state;
   chk_state_e        state_nx;
   logic [15:0]       delay_cnt;
   logic [DATA_W-1:0] exp_data;
   logic [BIDX_W-1:0] beat_idx;
   logic              tready_q;
   logic              bp_ok;
   logic              acc;
   logic              last_pos;
   logic [USER_W-1:0] exp_user;
   logic [3:0]        errs;

`ifdef AXIS_CHK_BACKPRESSURE_EN
   axis_chk_lfsr u_lfsr (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .en       (state == RUN),
      .ready_nx (bp_ok)
   );
`else
   assign bp_ok = 1'b1;
`endif

   assign s_axis_tready = tready_q;
   assign halted        = (state == HALT);
   assign acc           = s_axis_tvalid && tready_q;
   assign last_pos      = (beat_idx == BIDX_W'(FRAME_BEATS - 1));
   assign exp_user      = USER_W'(beat_idx == '0);

   always_comb begin
      errs           = 4'b0000;
      errs[ERR_DATA] = (s_axis_tdata != exp_data);
      errs[ERR_LAST] = (s_axis_tlast != last_pos);
      errs[ERR_KEEP] = (s_axis_tkeep != {KEEP_W{1'b1}});
      errs[ERR_USER] = (s_axis_tuser != exp_user);
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         WAIT:
            if (32'(delay_cnt) + 1 >= START_DELAY)
               state_nx = RUN;
         RUN:
            if (HALT_ON_ERR != 0 && acc && (|errs))
               state_nx = HALT;
         HALT:
            state_nx = HALT;
         default:
            state_nx = WAIT;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= WAIT;
         delay_cnt <= '0;
         tready_q  <= 1'b0;
      end else begin
         state    <= state_nx;
         tready_q <= (state_nx == RUN) && bp_ok;
         if (state == WAIT)
            delay_cnt <= delay_cnt + 16'd1;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         exp_data   <= '0;
         beat_idx   <= '0;
         frame_cnt  <= '0;
         err_cnt    <= '0;
         err_flags  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (acc) begin
            // Resync to received data so one bad beat is one error.
            exp_data  <= s_axis_tdata + DATA_W'(1);
            err_flags <= err_flags | errs;
            if (s_axis_tlast || last_pos)
               beat_idx <= '0;
            else
               beat_idx <= beat_idx + BIDX_W'(1);
            if ((|errs) && err_cnt != 16'hFFFF)
               err_cnt <= err_cnt + 16'd1;
            if (s_axis_tlast) begin
               frame_cnt  <= frame_cnt + 32'd1;
               frame_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_frame_checker.sv
// Self-checking bench for axis_frame_checker: directed frames,
// scoreboard on frame_done, tready reference model, halt instance.
module tb_axis_frame_checker;

   localparam int DW = 32;
   localparam int FB = 8;
   localparam int SD = 2;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;

   logic        tvalid = 1'b0;
   logic        tready;
   logic [31:0] tdata = '0;
   logic [3:0]  tkeep = '0;
   logic        tlast = 1'b0;
   logic [0:0]  tuser = '0;
   logic [31:0] frame_cnt;
   logic [15:0] err_cnt;
   logic [3:0]  err_flags;
   logic        frame_done;
   logic        halted;

   logic        h_tvalid = 1'b0;
   logic        h_tready;
   logic [31:0] h_tdata = '0;
   logic [3:0]  h_tkeep = '0;
   logic        h_tlast = 1'b0;
   logic [0:0]  h_tuser = '0;
   logic [31:0] h_frame_cnt;
   logic [15:0] h_err_cnt;
   logic [3:0]  h_err_flags;
   logic        h_frame_done;
   logic        h_halted;

   always #5 aclk = ~aclk;

   axis_frame_checker #(
      .DATA_W(DW), .KEEP_W(DW / 8), .USER_W(1),
      .FRAME_BEATS(FB), .START_DELAY(SD), .HALT_ON_ERR(0)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tvalid(tvalid), .s_axis_tready(tready),
      .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
      .s_axis_tlast(tlast), .s_axis_tuser(tuser),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt),
      .err_flags(err_flags), .frame_done(frame_done),
      .halted(halted)
   );

   axis_frame_checker #(
      .DATA_W(DW), .KEEP_W(DW / 8), .USER_W(1),
      .FRAME_BEATS(FB), .START_DELAY(SD), .HALT_ON_ERR(1)
   ) dut_h (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tvalid(h_tvalid), .s_axis_tready(h_tready),
      .s_axis_tdata(h_tdata), .s_axis_tkeep(h_tkeep),
      .s_axis_tlast(h_tlast), .s_axis_tuser(h_tuser),
      .frame_cnt(h_frame_cnt), .err_cnt(h_err_cnt),
      .err_flags(h_err_flags), .frame_done(h_frame_done),
      .halted(h_halted)
   );

   typedef struct packed {
      logic [31:0] fc;
      logic [15:0] ec;
      logic [3:0]  ef;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_done = 0;

   logic [31:0] m_exp;
   int          m_idx;
   logic [15:0] m_errc;
   logic [3:0]  m_flags;
   logic [31:0] m_frames;

   int          mt_rel = 0;
   logic [15:0] mt_lfsr = 16'hACE1;
   logic        exp_rdy;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      logic fb;
      fb = l[0] ^ l[2] ^ l[3] ^ l[5];
      return {fb, l[15:1]};
   endfunction

   // Reference for tready: START_DELAY cycles low, then per-cycle rule.
   always @(posedge aclk) begin
      if (!aresetn) begin
         mt_rel  = 0;
         mt_lfsr = 16'hACE1;
      end else if (mt_rel >= SD) begin
         mt_lfsr = lfsr_step(mt_lfsr);
      end else begin
         mt_rel++;
      end
   end

`ifdef AXIS_CHK_BACKPRESSURE_EN
   assign exp_rdy = (mt_rel >= SD) && (mt_lfsr[1:0] != 2'b00);
`else
   assign exp_rdy = (mt_rel >= SD);
`endif

   always @(negedge aclk) begin
      exp_t e;
      chk("tready", {31'd0, tready}, {31'd0, exp_rdy});
      if (frame_done === 1'b1) begin
         n_done++;
         if (sbq.size() == 0) begin
            chk("sb_unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("sb_frame_cnt", frame_cnt, e.fc);
            chk("sb_err_cnt", {16'd0, err_cnt}, {16'd0, e.ec});
            chk("sb_err_flags", {28'd0, err_flags}, {28'd0, e.ef});
         end
      end
   end

   task automatic model_clear();
      m_exp    = '0;
      m_idx    = 0;
      m_errc   = '0;
      m_flags  = '0;
      m_frames = '0;
   endtask

   task automatic do_reset(input int cyc);
      tvalid   = 1'b0;
      h_tvalid = 1'b0;
      aresetn  = 1'b0;
      repeat (cyc) @(posedge aclk);
      @(negedge aclk);
      chk("rst_frame_cnt", frame_cnt, 32'd0);
      chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("rst_err_flags", {28'd0, err_flags}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_h_tready", {31'd0, h_tready}, 32'd0);
      chk("rst_h_halted", {31'd0, h_halted}, 32'd0);
      chk("sb_drained", sbq.size(), 32'd0);
      aresetn = 1'b1;
      model_clear();
      @(posedge aclk);
      #1;
      n_done = 0;
   endtask

   task automatic idle(input int n);
      tvalid = 1'b0;
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] k,
                       input logic u, input logic l);
      logic       r;
      int         w;
      logic [3:0] e;
      tvalid = 1'b1;
      tdata  = d;
      tkeep  = k;
      tuser  = u;
      tlast  = l;
      w = 0;
      do begin
         @(negedge aclk);
         r = tready;
         @(posedge aclk);
         #1;
         w++;
      end while (!r && w < 200);
      if (!r) begin
         chk("accept_timeout", 32'd0, 32'd1);
         tvalid = 1'b0;
         return;
      end
      e = {(u !== (m_idx == 0)), (k !== 4'hF),
           (l !== (m_idx == FB - 1)), (d !== m_exp)};
      m_exp   = d + 32'd1;
      m_idx   = (l || m_idx == FB - 1) ? 0 : m_idx + 1;
      m_flags = m_flags | e;
      if ((|e) && m_errc != 16'hFFFF)
         m_errc++;
      if (l) begin
         m_frames++;
         sbq.push_back('{m_frames, m_errc, m_flags});
      end
   endtask

   task automatic frame(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++)
         send(base + i, 4'hF, i == 0, i == n - 1);
   endtask

   task automatic send_h(input logic [31:0] d, input logic [3:0] k,
                         input logic u);
      logic r;
      int   w;
      h_tvalid = 1'b1;
      h_tdata  = d;
      h_tkeep  = k;
      h_tuser  = u;
      h_tlast  = 1'b0;
      w = 0;
      do begin
         @(negedge aclk);
         r = h_tready;
         @(posedge aclk);
         #1;
         w++;
      end while (!r && w < 200);
      if (!r)
         chk("h_accept_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_clear();
      do_reset(3);
      @(negedge aclk);
      chk("wait_tready_lo", {31'd0, tready}, 32'd0);
      @(negedge aclk);
      chk("run_tready_hi", {31'd0, tready}, 32'd1);
      @(posedge aclk);
      #1;

      frame(32'd0, FB);
      frame(32'd8, FB);
      idle(2);
      frame(32'd16, FB);
      idle(3);
      chk("clean_frame_cnt", frame_cnt, 32'd3);
      chk("clean_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("clean_err_flags", {28'd0, err_flags}, 32'd0);
      chk("clean_done_pulses", n_done, 32'd3);

      do_reset(2);
      for (int i = 0; i < FB; i++)
         send(i < 5 ? i : 32'h50 + i, 4'hF, i == 0, i == FB - 1);
      idle(3);
      chk("data_err_flags", {28'd0, err_flags}, 32'h1);
      chk("data_err_cnt", {16'd0, err_cnt}, 32'd1);

      do_reset(2);
      frame(32'd0, 4);
      frame(32'd4, FB);
      idle(3);
      chk("last_err_flag1", {31'd0, err_flags[1]}, 32'd1);
      chk("last_err_cnt", {16'd0, err_cnt}, 32'd1);
      chk("last_frame_cnt", frame_cnt, 32'd2);

      do_reset(2);
      frame(32'd0, FB);
      send(32'd8, 4'hF, 1'b1, 1'b0);
      send(32'd9, 4'hF, 1'b0, 1'b0);
      send(32'd10, 4'hF, 1'b0, 1'b0);
      do_reset(1);
      frame(32'd0, FB);
      frame(32'd8, FB);
      idle(3);
      chk("rst_mid_frame_cnt", frame_cnt, 32'd2);
      chk("rst_mid_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("rst_mid_err_flags", {28'd0, err_flags}, 32'd0);

      do_reset(2);
      for (int f = 0; f < 100; f++) begin
         frame(32'(f * FB), FB);
         if (f % 7 == 0)
            idle(1);
      end
      idle(3);
      chk("bulk_frame_cnt", frame_cnt, 32'd100);
      chk("bulk_err_cnt", {16'd0, err_cnt}, 32'd0);
      chk("bulk_done_pulses", n_done, 32'd100);

      send_h(32'd0, 4'hF, 1'b1);
      send_h(32'd1, 4'hF, 1'b0);
      send_h(32'd2, 4'hE, 1'b0);
      h_tdata = 32'd3;
      h_tkeep = 4'hF;
      @(negedge aclk);
      chk("halt_tready_lo", {31'd0, h_tready}, 32'd0);
      chk("halt_halted", {31'd0, h_halted}, 32'd1);
      chk("halt_err_flags", {28'd0, h_err_flags}, 32'h4);
      chk("halt_err_cnt", {16'd0, h_err_cnt}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         chk("halt_stall", {31'd0, h_tready}, 32'd0);
      end
      chk("halt_err_cnt_hold", {16'd0, h_err_cnt}, 32'd1);
      chk("halt_frame_cnt", h_frame_cnt, 32'd0);
      chk("halt_no_done", {31'd0, h_frame_done}, 32'd0);
      h_tvalid = 1'b0;

      chk("sb_final_empty", sbq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_frame_checker.md
AXIS_FRAME_CHECKER -- requirements
Module: axis_frame_checker

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 32, tdata width; multiple of 8, at most 32.
- KEEP_W, DATA_W/8, tkeep width.
- USER_W, 1, tuser width.
- FRAME_BEATS, 8, beats per frame; at least 2.
- START_DELAY, 2, cycles tready is held low after reset.
- HALT_ON_ERR, 0, value 1 stops accepting beats at the first error.
REQ-002 Ports SHALL be, one per line:
- aclk, in, 1, clock.
- aresetn, in, 1, synchronous active-low reset.
- s_axis_tvalid, in, 1, beat valid.
- s_axis_tready, out, 1, beat ready; registered.
- s_axis_tdata, in, DATA_W, beat data.
- s_axis_tkeep, in, KEEP_W, byte enables.
- s_axis_tlast, in, 1, end of frame.
- s_axis_tuser, in, USER_W, start-of-frame marker.
- frame_cnt, out, 32, frames received; wraps.
- err_cnt, out, 16, beats with any error; saturates at 0xFFFF.
- err_flags, out, 4, sticky error bits: [0] data, [1] last, [2] keep, [3] user.
- frame_done, out, 1, one-cycle pulse per accepted tlast.
- halted, out, 1, high while the block is in state HALT.
REQ-003 Reset SHALL be aresetn, synchronous, active-low; clock SHALL be aclk.

Function
REQ-004 A beat is accepted when s_axis_tvalid and s_axis_tready are both high at a rising edge of aclk.
REQ-005 The FSM SHALL have three states:
- WAIT: tready low; counts START_DELAY cycles after reset, then moves to RUN.
- RUN: tready driven per REQ-013 and REQ-014.
- HALT: tready low; the only exit is reset.
REQ-006 The expected stream per accepted beat SHALL be:
- tdata = exp_data, where exp_data is 0 after reset, increments by 1 per accepted beat and wraps modulo 2^DATA_W.
- tkeep = all ones.
- tuser = 1 when beat_idx = 0, else 0.
- tlast = 1 when beat_idx = FRAME_BEATS-1, else 0.
REQ-007 After an accepted beat, exp_data SHALL become tdata+1, so a single corrupt beat causes exactly one data error.
REQ-008 beat_idx SHALL reset to 0 after any accepted tlast, including an early tlast; otherwise it increments by 1.
- If beat_idx reaches FRAME_BEATS-1 without tlast, a last error is flagged and beat_idx returns to 0.
REQ-009 On any accepted tlast, valid or not:
- frame_cnt increments by 1 in the next cycle.
- frame_done pulses high in the next cycle.
REQ-010 Per accepted beat:
- err_flags bits are OR-ed with the current beat's mismatches and stay set until reset.
- err_cnt increments by 1 if any mismatch is present, regardless of how many bits mismatch.
REQ-011 When HALT_ON_ERR=1, the first errored beat moves RUN to HALT; tready is low from the next cycle and halted goes high.
REQ-012 While tvalid is low, no counter and no flag SHALL change.

Configuration
REQ-013 With AXIS_CHK_BACKPRESSURE_EN defined:
- In RUN, tready = (lfsr[1:0] != 2'b00).
- lfsr is a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1, advancing every RUN cycle.
REQ-014 With AXIS_CHK_BACKPRESSURE_EN undefined, tready SHALL be 1 throughout RUN and no LFSR logic SHALL be built.

Reset
REQ-015 While aresetn=0, all of the following SHALL take these values at every clock edge:
- state = WAIT, tready = 0.
- frame_cnt = 0, err_cnt = 0, err_flags = 0.
- frame_done = 0, halted = 0.
- exp_data = 0, beat_idx = 0, lfsr = 0xACE1.
REQ-016 Reset asserted mid-frame SHALL discard the partial frame; checking restarts at exp_data=0, beat_idx=0.

Structure
REQ-017 Package axis_chk_pkg SHALL hold:
- the state enum (WAIT, RUN, HALT);
- err_flags bit indices;
- LFSR seed and tap constants.
REQ-018 The LFSR SHALL be sub-module axis_chk_lfsr, instantiated only under AXIS_CHK_BACKPRESSURE_EN.

Verification
REQ-019 Macro undefined, 3 clean frames, FRAME_BEATS=8, data 0..23:
- tready rises 2 cycles after reset release.
- frame_cnt=3, 3 frame_done pulses, err_cnt=0, err_flags=0.
REQ-020 Beat 5 data 0x5 replaced by 0x55, frame otherwise clean:
- err_flags=4'b0001, err_cnt=1.
- The following beat 0x56 is not flagged.
REQ-021 tlast on beat index 3 (4-beat frame), then a normal frame starting at data 4:
- err_flags[1]=1, err_cnt=1.
- frame_cnt=2; the second frame passes.
REQ-022 HALT_ON_ERR=1, tkeep=0xE on beat 2:
- err_flags=4'b0100, halted=1.
- tready=0 from the next cycle; the source stalls.
REQ-023 Macro defined, 100 clean frames:
- tready pattern matches the LFSR reference model.
- frame_cnt=100, err_cnt=0.
REQ-024 aresetn pulsed low for 1 cycle mid-frame 2, then frames restarted at data 0:
- All counters return to 0; checking resumes with no errors.
